// File: rtl/usb_msd_cbw_parser_if.sv
// Bulk-OUT receive stream and decoded-CBW handshake between RX path, parser and SCSI engine.
interface usb_msd_cbw_parser_if;
  logic [7:0]   rx_dat_i;
  logic         rx_val_i;
  logic         rx_end_i;
  logic         rx_rdy_o;
  logic         cbw_vld_o;
  logic         cbw_rdy_i;
  logic [31:0]  cbw_tag_o;
  logic [31:0]  cbw_dlen_o;
  logic         cbw_dir_in_o;
  logic [3:0]   cbw_lun_o;
  logic [4:0]   cbw_cblen_o;
  logic [127:0] cbw_cdb_o;

  // Upstream RX path plus downstream CBW consumer
  modport master (
    output rx_dat_i, rx_val_i, rx_end_i, cbw_rdy_i,
    input  rx_rdy_o, cbw_vld_o, cbw_tag_o, cbw_dlen_o, cbw_dir_in_o,
           cbw_lun_o, cbw_cblen_o, cbw_cdb_o
  );

  // The CBW parser
  modport slave (
    input  rx_dat_i, rx_val_i, rx_end_i, cbw_rdy_i,
    output rx_rdy_o, cbw_vld_o, cbw_tag_o, cbw_dlen_o, cbw_dir_in_o,
           cbw_lun_o, cbw_cblen_o, cbw_cdb_o
  );
endinterface

// File: rtl/usb_msd_cbw_parser.sv
// Assembles 31-byte MSD Command Block Wrappers from the bulk-OUT stream,
// validates them and hands the decoded fields to the SCSI engine.
module usb_msd_cbw_parser #(
  parameter int unsigned MAX_LUN   = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 abort_i,
  usb_msd_cbw_parser_if.slave  bus,
  output logic                 cbw_err_o,
  output logic [1:0]           cbw_err_code_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned CNT_W    = 6;
  localparam logic [CNT_W-1:0] CBW_LEN  = 6'd31;
  localparam logic [CNT_W-1:0] CNT_MAX  = 6'd32;
  localparam logic [31:0]      CBW_SIG  = 32'h4342_5355;
  localparam logic [4:0]       CB_MAX   = 5'd16;

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [31:0]          sig_q;
  logic [31:0]          tag_q;
  logic [31:0]          dlen_q;
  logic                 dir_q;
  logic [3:0]           lun_q;
  logic [4:0]           cblen_q;
  logic [127:0]         cdb_q;
  logic                 rx_rdy_q;
  logic                 vld_q;
  logic                 err_q;
  logic [1:0]           code_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 accept_d;
  logic                 eval_d;
  logic [1:0]           code_d;
  logic [3:0]           cdb_idx_d;

  // Byte acceptance, running count and end-of-packet verdict
  always_comb begin
    accept_d  = bus.rx_val_i & rx_rdy_q;
    cnt_d     = cnt_q;
    if (accept_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 6'd1;
    eval_d    = bus.rx_end_i & ((state_q == RECV) | ((state_q == IDLE) & accept_d));
    cdb_idx_d = 4'(cnt_q - 6'd15);
    // Header bytes 0..14 are already stored whenever the final count is 31
    code_d = 2'd0;
    if (cnt_d != CBW_LEN)                               code_d = 2'd1;
    else if (sig_q != CBW_SIG)                          code_d = 2'd2;
    else if ((32'(lun_q) > MAX_LUN) || (cblen_q == 5'd0) ||
             (cblen_q > CB_MAX))                        code_d = 2'd3;
  end

  // Parser FSM, field capture and error bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sig_q     <= '0;
      tag_q     <= '0;
      dlen_q    <= '0;
      dir_q     <= 1'b0;
      lun_q     <= '0;
      cblen_q   <= '0;
      cdb_q     <= '0;
      rx_rdy_q  <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      err_cnt_q <= '0;
    end else if (abort_i) begin
      // Class reset: drop everything in flight but keep the error history
      state_q  <= IDLE;
      cnt_q    <= '0;
      sig_q    <= '0;
      tag_q    <= '0;
      dlen_q   <= '0;
      dir_q    <= 1'b0;
      lun_q    <= '0;
      cblen_q  <= '0;
      cdb_q    <= '0;
      rx_rdy_q <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;

      if (accept_d && (cnt_q < CBW_LEN)) begin
        if (cnt_q < 6'd4)        sig_q[{cnt_q[1:0], 3'b000} +: 8]  <= bus.rx_dat_i;
        else if (cnt_q < 6'd8)   tag_q[{cnt_q[1:0], 3'b000} +: 8]  <= bus.rx_dat_i;
        else if (cnt_q < 6'd12)  dlen_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.rx_dat_i;
        else if (cnt_q == 6'd12) dir_q   <= bus.rx_dat_i[7];
        else if (cnt_q == 6'd13) lun_q   <= bus.rx_dat_i[3:0];
        else if (cnt_q == 6'd14) cblen_q <= bus.rx_dat_i[4:0];
        else                     cdb_q[{cdb_idx_d, 3'b000} +: 8] <= bus.rx_dat_i;
      end

      if (eval_d) begin
        cnt_q <= '0;
        if (code_d == 2'd0) begin
          state_q  <= HOLD;
          vld_q    <= 1'b1;
          rx_rdy_q <= 1'b0;
        end else begin
          state_q  <= IDLE;
          rx_rdy_q <= 1'b1;
          err_q    <= 1'b1;
          code_q   <= code_d;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
      end else begin
        case (state_q)
          IDLE: begin
            rx_rdy_q <= 1'b1;
            if (accept_d) begin
              cnt_q   <= cnt_d;
              state_q <= RECV;
            end
          end
          RECV: begin
            rx_rdy_q <= 1'b1;
            cnt_q    <= cnt_d;
          end
          HOLD: begin
            if (bus.cbw_rdy_i) begin
              vld_q    <= 1'b0;
              rx_rdy_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_rdy_o     = rx_rdy_q;
  assign bus.cbw_vld_o    = vld_q;
  assign bus.cbw_tag_o    = tag_q;
  assign bus.cbw_dlen_o   = dlen_q;
  assign bus.cbw_dir_in_o = dir_q;
  assign bus.cbw_lun_o    = lun_q;
  assign bus.cbw_cblen_o  = cblen_q;
  assign bus.cbw_cdb_o    = cdb_q;
  assign cbw_err_o        = err_q;
  assign cbw_err_code_o   = code_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_usb_msd_cbw_parser.sv
// Self-checking bench for usb_msd_cbw_parser: packet-level reference model plus directed tests.
module tb_usb_msd_cbw_parser;

  localparam int unsigned MAX_LUN   = 0;
  localparam int unsigned ERR_CNT_W = 8;

  logic clk;
  logic rst;
  logic abort;
  logic cbw_err;
  logic [1:0] cbw_err_code;
  logic [ERR_CNT_W-1:0] err_cnt;

  usb_msd_cbw_parser_if bus();

  usb_msd_cbw_parser #(.MAX_LUN(MAX_LUN), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .abort_i        (abort),
    .bus            (bus),
    .cbw_err_o      (cbw_err),
    .cbw_err_code_o (cbw_err_code),
    .err_cnt_o      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  logic [7:0]   m_b [0:30];
  int           m_len;
  logic         m_rdy, m_vld, m_err;
  logic [1:0]   m_code;
  int           m_ecnt;
  logic [31:0]  m_tag, m_dlen;
  logic         m_dir;
  logic [3:0]   m_lun;
  logic [4:0]   m_cblen;
  logic [127:0] m_cdb;

  function automatic int judge(input logic [7:0] b [0:30], input int n);
    logic [31:0] sig;
    int lun, cbl;
    if (n != 31) return 1;
    sig = {b[3], b[2], b[1], b[0]};
    if (sig != 32'h43425355) return 2;
    lun = int'(b[13][3:0]);
    cbl = int'(b[14][4:0]);
    if (lun > int'(MAX_LUN) || cbl == 0 || cbl > 16) return 3;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [7:0]   b [0:30];
    logic [127:0] cdb;
    int n, code;
    logic acc;
    if (rst) begin
      m_len <= 0; m_rdy <= 1'b0; m_vld <= 1'b0; m_err <= 1'b0;
      m_code <= 2'd0; m_ecnt <= 0;
    end else if (abort) begin
      m_len <= 0; m_rdy <= 1'b0; m_vld <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      acc = bus.rx_val_i && m_rdy;
      if (m_vld) begin
        if (bus.cbw_rdy_i) begin
          m_vld <= 1'b0;
          m_rdy <= 1'b1;
        end
      end else begin
        m_rdy <= 1'b1;
        b = m_b;
        n = m_len;
        if (acc) begin
          if (n < 31) b[n] = bus.rx_dat_i;
          if (n < 40) n++;
        end
        m_b <= b;
        if (bus.rx_end_i && n > 0) begin
          m_len <= 0;
          code = judge(b, n);
          if (code == 0) begin
            for (int k = 0; k < 16; k++) cdb[8*k +: 8] = b[15+k];
            m_vld   <= 1'b1;
            m_rdy   <= 1'b0;
            m_tag   <= {b[7], b[6], b[5], b[4]};
            m_dlen  <= {b[11], b[10], b[9], b[8]};
            m_dir   <= b[12][7];
            m_lun   <= b[13][3:0];
            m_cblen <= b[14][4:0];
            m_cdb   <= cdb;
          end else begin
            m_err  <= 1'b1;
            m_code <= 2'(code);
            m_ecnt <= (m_ecnt < 255) ? m_ecnt + 1 : 255;
          end
        end else begin
          m_len <= n;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rx_rdy", 128'(bus.rx_rdy_o), 128'(m_rdy));
      chk("vld", 128'(bus.cbw_vld_o), 128'(m_vld));
      chk("err", 128'(cbw_err), 128'(m_err));
      chk("err_code", 128'(cbw_err_code), 128'(m_code));
      chk("err_cnt", 128'(err_cnt), 128'(m_ecnt));
      if (m_vld) begin
        chk("tag", 128'(bus.cbw_tag_o), 128'(m_tag));
        chk("dlen", 128'(bus.cbw_dlen_o), 128'(m_dlen));
        chk("dir", 128'(bus.cbw_dir_in_o), 128'(m_dir));
        chk("lun", 128'(bus.cbw_lun_o), 128'(m_lun));
        chk("cblen", 128'(bus.cbw_cblen_o), 128'(m_cblen));
        chk("cdb", bus.cbw_cdb_o, m_cdb);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pkt [0:31];

  task automatic fill_good();
    for (int i = 0; i < 32; i++) pkt[i] = 8'h00;
    pkt[0] = 8'h55; pkt[1] = 8'h53; pkt[2] = 8'h42; pkt[3] = 8'h43;
    pkt[4] = 8'h78; pkt[5] = 8'h56; pkt[6] = 8'h34; pkt[7] = 8'h12;
    pkt[8] = 8'h00; pkt[9] = 8'h10; pkt[10] = 8'h00; pkt[11] = 8'h00;
    pkt[12] = 8'h80; pkt[13] = 8'h00; pkt[14] = 8'h0A;
    pkt[15] = 8'h28; pkt[19] = 8'h01; pkt[23] = 8'h08; pkt[30] = 8'hAB;
  endtask

  task automatic send(input int n, input bit with_end);
    for (int i = 0; i < n; i++) begin
      bus.rx_dat_i = pkt[i];
      bus.rx_val_i = 1'b1;
      bus.rx_end_i = with_end && (i == n - 1);
      @(negedge clk);
    end
    bus.rx_val_i = 1'b0;
    bus.rx_end_i = 1'b0;
    bus.rx_dat_i = 8'h00;
  endtask

  initial begin
    rst = 1'b0; abort = 1'b0;
    bus.rx_dat_i = 8'h00; bus.rx_val_i = 1'b0; bus.rx_end_i = 1'b0; bus.cbw_rdy_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset rx_rdy", 128'(bus.rx_rdy_o), 128'd0);
    chk("reset vld", 128'(bus.cbw_vld_o), 128'd0);
    chk("reset err_cnt", 128'(err_cnt), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rx_rdy reset cycle", 128'(bus.rx_rdy_o), 128'd0);
    @(negedge clk);
    chk("rx_rdy after reset", 128'(bus.rx_rdy_o), 128'd1);

    // 1. valid READ(10) CBW, held then consumed
    fill_good();
    send(31, 1'b1);
    chk("t1 vld", 128'(bus.cbw_vld_o), 128'd1);
    chk("t1 tag", 128'(bus.cbw_tag_o), 128'h12345678);
    chk("t1 dlen", 128'(bus.cbw_dlen_o), 128'h00001000);
    chk("t1 dir_in", 128'(bus.cbw_dir_in_o), 128'd1);
    chk("t1 cblen", 128'(bus.cbw_cblen_o), 128'd10);
    chk("t1 cdb0", 128'(bus.cbw_cdb_o[7:0]), 128'h28);
    chk("t1 cdb15", 128'(bus.cbw_cdb_o[127:120]), 128'hAB);
    chk("t1 rx_rdy", 128'(bus.rx_rdy_o), 128'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1 hold vld", 128'(bus.cbw_vld_o), 128'd1);
      chk("t1 hold tag", 128'(bus.cbw_tag_o), 128'h12345678);
    end
    bus.cbw_rdy_i = 1'b1;
    @(negedge clk);
    bus.cbw_rdy_i = 1'b0;
    chk("t1 vld after xfer", 128'(bus.cbw_vld_o), 128'd0);
    chk("t1 rx_rdy after xfer", 128'(bus.rx_rdy_o), 128'd1);

    // 2. wrong lengths
    send(30, 1'b1);
    chk("t2 err30", 128'(cbw_err), 128'd1);
    chk("t2 code30", 128'(cbw_err_code), 128'd1);
    chk("t2 cnt30", 128'(err_cnt), 128'd1);
    send(32, 1'b1);
    chk("t2 err32", 128'(cbw_err), 128'd1);
    chk("t2 cnt32", 128'(err_cnt), 128'd2);
    chk("t2 no vld", 128'(bus.cbw_vld_o), 128'd0);

    // 3. signature and field errors
    pkt[0] = 8'h56;
    send(31, 1'b1);
    chk("t3 sig code", 128'(cbw_err_code), 128'd2);
    fill_good(); pkt[13] = 8'h01;
    send(31, 1'b1);
    chk("t3 lun code", 128'(cbw_err_code), 128'd3);
    fill_good(); pkt[14] = 8'h00;
    send(31, 1'b1);
    chk("t3 cblen0 code", 128'(cbw_err_code), 128'd3);
    fill_good(); pkt[14] = 8'h11;
    send(31, 1'b1);
    chk("t3 cblen17 err", 128'(cbw_err), 128'd1);
    chk("t3 cblen17 cnt", 128'(err_cnt), 128'd6);

    // 4. zero-length packet
    bus.rx_end_i = 1'b1;
    @(negedge clk);
    bus.rx_end_i = 1'b0;
    chk("t4 no err", 128'(cbw_err), 128'd0);
    chk("t4 cnt", 128'(err_cnt), 128'd6);

    // 5. abort mid-packet, then a good CBW; abort in HOLD
    fill_good(); pkt[4] = 8'hEF; pkt[5] = 8'hBE;
    send(12, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5 rx_rdy abort", 128'(bus.rx_rdy_o), 128'd0);
    @(negedge clk);
    fill_good(); pkt[4] = 8'h01; pkt[5] = 8'h02; pkt[6] = 8'h03; pkt[7] = 8'h04;
    send(31, 1'b1);
    chk("t5 vld", 128'(bus.cbw_vld_o), 128'd1);
    chk("t5 tag", 128'(bus.cbw_tag_o), 128'h04030201);
    chk("t5 err_cnt", 128'(err_cnt), 128'd6);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5 vld after abort", 128'(bus.cbw_vld_o), 128'd0);
    chk("t5 code kept", 128'(cbw_err_code), 128'd3);
    chk("t5 cnt kept", 128'(err_cnt), 128'd6);
    @(negedge clk);

    // 6. saturation, then asynchronous reset mid-packet
    bus.rx_dat_i = 8'h00; bus.rx_val_i = 1'b1; bus.rx_end_i = 1'b1;
    repeat (300) @(negedge clk);
    bus.rx_val_i = 1'b0; bus.rx_end_i = 1'b0;
    chk("t6 saturated", 128'(err_cnt), 128'd255);
    fill_good();
    send(20, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst rx_rdy", 128'(bus.rx_rdy_o), 128'd0);
    chk("t6 rst vld", 128'(bus.cbw_vld_o), 128'd0);
    chk("t6 rst err", 128'(cbw_err), 128'd0);
    chk("t6 rst code", 128'(cbw_err_code), 128'd0);
    chk("t6 rst cnt", 128'(err_cnt), 128'd0);
    chk("t6 rst tag", 128'(bus.cbw_tag_o), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
